perceptron_layer_seq: RTL



---
 rtl/perceptron_layer_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/perceptron_layer_seq.sv
// perceptron_layer_seq: run-time programmable layer of binary-input perceptrons.
// All N_OUT neurons accumulate in parallel, one input bit per cycle, and the
// thresholded result is returned on a valid/ready port.
module perceptron_layer_seq #(
    parameter int N_IN    = 8,
    parameter int N_OUT   = 8,
    parameter int W_WIDTH = 8,
    parameter int ACC_W   = W_WIDTH + $clog2(N_IN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_IN-1:0]          in_bits,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_OUT-1:0]         out_bits,
    input  logic                     cfg_we,
    input  logic                     cfg_is_thr,
    input  logic [$clog2(N_OUT)-1:0] cfg_neuron,
    input  logic [$clog2(N_IN)-1:0]  cfg_input,
    input  logic [ACC_W-1:0]         cfg_data,
    output logic                     cfg_err
);
    localparam int IDX_W = $clog2(N_IN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [W_WIDTH-1:0] w       [N_OUT][N_IN];
    logic [ACC_W-1:0]   thr     [N_OUT];
    logic [ACC_W-1:0]   acc     [N_OUT];
    logic [ACC_W-1:0]   acc_sum [N_OUT];
    logic [N_IN-1:0]    in_bits_q;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        cfg_neuron_ext;
    logic [31:0]        cfg_input_ext;
    logic               cfg_in_range;
    logic               cfg_accept;
    logic               in_fire;

    // Next-state logic and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ACCUM;
            end
            ACCUM: begin
                if (idx == IDX_LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Configuration write decode: range check is independent of state
    always_comb begin
        cfg_neuron_ext = 32'(cfg_neuron);
        cfg_input_ext  = 32'(cfg_input);
        cfg_in_range   = (cfg_neuron_ext < N_OUT) &&
                         (cfg_is_thr || (cfg_input_ext < N_IN));
        cfg_accept     = cfg_we && cfg_in_range && (state == IDLE);
        in_fire        = in_valid && in_ready;
    end

    // Per-neuron running sum including the current input's contribution
    always_comb begin
        for (int unsigned j = 0; j < N_OUT; j++) begin
            acc_sum[j] = acc[j] + (in_bits_q[idx] ? ACC_W'(w[j][idx]) : '0);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Vector capture, serial accumulation and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_bits_q <= '0;
            idx       <= '0;
            out_bits  <= '0;
            for (int unsigned j = 0; j < N_OUT; j++) acc[j] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_fire) begin
                        in_bits_q <= in_bits;
                        idx       <= '0;
                        for (int unsigned j = 0; j < N_OUT; j++) acc[j] <= '0;
                    end
                end
                ACCUM: begin
                    for (int unsigned j = 0; j < N_OUT; j++) acc[j] <= acc_sum[j];
                    if (idx == IDX_LAST) begin
                        for (int unsigned j = 0; j < N_OUT; j++) begin
                            out_bits[j] <= (acc_sum[j] >= thr[j]);
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Weight and threshold storage, writable only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < N_OUT; j++) begin
                thr[j] <= '0;
                for (int unsigned i = 0; i < N_IN; i++) w[j][i] <= '0;
            end
        end else if (cfg_accept) begin
            for (int unsigned j = 0; j < N_OUT; j++) begin
                if (cfg_neuron_ext == j) begin
                    if (cfg_is_thr) begin
                        thr[j] <= cfg_data;
                    end else begin
                        for (int unsigned i = 0; i < N_IN; i++) begin
                            if (cfg_input_ext == i) w[j][i] <= cfg_data[W_WIDTH-1:0];
                        end
                    end
                end
            end
        end
    end

    // One-cycle error pulse for any dropped configuration write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cfg_err <= 1'b0;
        else        cfg_err <= cfg_we && !(cfg_in_range && (state == IDLE));
    end

endmodule
